// File: rtl/rom_arbiter_if.sv
// Request/response bundle between the core ports, the ROM and rom_arbiter.
// The slave modport is the arbiter's view; master is the core plus ROM side.
interface rom_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;

  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [31:0] ld_req_addr;
  logic        ld_rsp_valid;
  logic        ld_rsp_ready;
  logic [31:0] ld_rsp_data;
  logic        ld_rsp_err;

  logic [31:0] rom_pc;
  logic [31:0] rom_instruction;

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  ld_req_valid, ld_req_addr, ld_rsp_ready,
    input  rom_instruction,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
    output rom_pc
  );

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output ld_req_valid, ld_req_addr, ld_rsp_ready,
    output rom_instruction,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
    input  rom_pc
  );
endinterface

// File: rtl/rom_arbiter.sv
// Shares the combinational ROM read port between instruction fetch and data load.
// Define ROM_ARB_RR_EN for strict round-robin; otherwise load priority with a fetch starvation guard.
module rom_arbiter #(
  parameter int DEPTH_LOG2 = 4,
  parameter int STARVE_MAX = 3
) (
  input logic         clk,
  input logic         rst_n,
  rom_arbiter_if.slave bus
);

  localparam int P_IF = 0;
  localparam int P_LD = 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] req_addr;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic [1:0]       addr_bad;
  logic [1:0]       rsp_valid;
  logic [1:0][31:0] rsp_data;
  logic [1:0]       rsp_err;
  logic [31:0]      rom_pc_next;

  assign req_valid = {bus.ld_req_valid, bus.if_req_valid};
  assign rsp_ready = {bus.ld_rsp_ready, bus.if_rsp_ready};
  assign req_addr  = {bus.ld_req_addr, bus.if_req_addr};

  // ---------------------------------------------------------------------------
  // Per-port response slot: eligibility, address checking and slot FSM
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_slot
      slot_state_t state_reg;
      slot_state_t state_next;
      logic [31:0] data_reg;
      logic [31:0] data_next;
      logic        err_reg;
      logic        err_next;
      logic        out_of_range;
      logic        misaligned;

      // A draining slot can accept a new request in the same cycle.
      assign eligible[gi] = req_valid[gi] &
                            ((state_reg == SLOT_EMPTY) | rsp_ready[gi]);

      assign out_of_range = |req_addr[gi][31:DEPTH_LOG2+2];
      // Loads leave byte selection to the LSU, so only fetch checks alignment.
      assign misaligned   = (gi == P_IF) && (req_addr[gi][1:0] != 2'b00);
      assign addr_bad[gi] = out_of_range | misaligned;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= SLOT_EMPTY;
          data_reg  <= '0;
          err_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          data_reg  <= data_next;
          err_reg   <= err_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        if (grant[gi]) begin
          state_next = SLOT_FULL;
          data_next  = addr_bad[gi] ? 32'h0 : bus.rom_instruction;
          err_next   = addr_bad[gi];
        end else if ((state_reg == SLOT_FULL) && rsp_ready[gi]) begin
          state_next = SLOT_EMPTY;
        end
      end

      assign rsp_valid[gi] = (state_reg == SLOT_FULL);
      assign rsp_data[gi]  = data_reg;
      assign rsp_err[gi]   = err_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ROM_ARB_RR_EN
  // Pointer names the port that wins the next tie: 0 = fetch, 1 = load.
  logic rr_ptr_reg;
  logic rr_ptr_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    grant       = eligible;
    rr_ptr_next = rr_ptr_reg;
    if (eligible == 2'b11) begin
      grant = rr_ptr_reg ? 2'b10 : 2'b01;
    end
    if (grant[P_IF]) begin
      rr_ptr_next = 1'b1;
    end else if (grant[P_LD]) begin
      rr_ptr_next = 1'b0;
    end
  end
`else
  localparam int SW_RAW = $clog2(STARVE_MAX + 1);
  localparam int SW     = (SW_RAW < 2) ? 2 : ((SW_RAW > 8) ? 8 : SW_RAW);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt_reg;
  logic [SW-1:0] starve_cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    grant           = eligible;
    starve_cnt_next = starve_cnt_reg;
    if (eligible == 2'b11) begin
      grant = (starve_cnt_reg == STARVE_LIM) ? 2'b01 : 2'b10;
    end
    // Fetch can only lose while eligible when load took the port.
    if (grant[P_IF]) begin
      starve_cnt_next = '0;
    end else if (eligible[P_IF] && (starve_cnt_reg != STARVE_LIM) &&
                 (starve_cnt_reg != {SW{1'b1}})) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end
`endif

  always_comb begin
    rom_pc_next = 32'h0;
    if (grant[P_IF]) begin
      rom_pc_next = {req_addr[P_IF][31:2], 2'b00};
    end else if (grant[P_LD]) begin
      rom_pc_next = {req_addr[P_LD][31:2], 2'b00};
    end
  end

  assign bus.rom_pc       = rom_pc_next;
  assign bus.if_req_ready = grant[P_IF];
  assign bus.ld_req_ready = grant[P_LD];
  assign bus.if_rsp_valid = rsp_valid[P_IF];
  assign bus.if_rsp_data  = rsp_data[P_IF];
  assign bus.if_rsp_err   = rsp_err[P_IF];
  assign bus.ld_rsp_valid = rsp_valid[P_LD];
  assign bus.ld_rsp_data  = rsp_data[P_LD];
  assign bus.ld_rsp_err   = rsp_err[P_LD];

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a small arbitration model plus per-port response scoreboards.
// Follows ROM_ARB_RR_EN the same way the design does.
module tb_rom_arbiter;
  localparam int DEPTH_LOG2 = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_arbiter_if bus();

  rom_arbiter #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    case (idx)
      30'd0:   return 32'h40000113;
      30'd1:   return 32'h01000193;
      30'd2:   return 32'h00108093;
      30'd3:   return 32'h00110023;
      default: return 32'hA5000000 | {2'b00, idx};
    endcase
  endfunction

  assign bus.rom_instruction = rom_word(bus.rom_pc[31:2]);

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: slot occupancy, starvation count, round-robin pointer.
  logic [1:0]  m_full;
  int          m_starve;
  logic        m_ptr;
  logic [32:0] q_if[$];
  logic [32:0] q_ld[$];
  logic        last_if_rdy;
  logic        last_ld_rdy;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {32'h0, obs}, {32'h0, exp});
  endtask

  function automatic logic [32:0] exp_rsp(input bit is_fetch, input logic [31:0] a);
    if ((a[31:DEPTH_LOG2+2] != '0) || (is_fetch && (a[1:0] != 2'b00)))
      return {1'b1, 32'h0};
    return {1'b0, rom_word(a[31:2])};
  endfunction

  task automatic model_reset();
    m_full   = 2'b00;
    m_starve = 0;
    m_ptr    = 1'b0;
    q_if.delete();
    q_ld.delete();
  endtask

  // Called away from the active edge: check responses, grants and rom_pc.
  task automatic sample();
    logic [1:0]  rv, rr, elig, eg;
    logic [31:0] exp_pc;
    rv = {bus.ld_req_valid, bus.if_req_valid};
    rr = {bus.ld_rsp_ready, bus.if_rsp_ready};

    check1("if_rsp_valid", bus.if_rsp_valid, m_full[0]);
    if (m_full[0]) begin
      if (q_if.size() == 0) check1("if_scoreboard_nonempty", 1'b0, 1'b1);
      else begin
        check("if_rsp", {bus.if_rsp_err, bus.if_rsp_data}, q_if[0]);
        if (rr[0]) void'(q_if.pop_front());
      end
    end
    check1("ld_rsp_valid", bus.ld_rsp_valid, m_full[1]);
    if (m_full[1]) begin
      if (q_ld.size() == 0) check1("ld_scoreboard_nonempty", 1'b0, 1'b1);
      else begin
        check("ld_rsp", {bus.ld_rsp_err, bus.ld_rsp_data}, q_ld[0]);
        if (rr[1]) void'(q_ld.pop_front());
      end
    end

    elig = rv & (~m_full | rr);
    eg   = elig;
    if (elig == 2'b11) begin
`ifdef ROM_ARB_RR_EN
      eg = m_ptr ? 2'b10 : 2'b01;
`else
      eg = (m_starve == STARVE_MAX) ? 2'b01 : 2'b10;
`endif
    end
    check1("if_req_ready", bus.if_req_ready, eg[0]);
    check1("ld_req_ready", bus.ld_req_ready, eg[1]);
    exp_pc = eg[0] ? {bus.if_req_addr[31:2], 2'b00} :
             eg[1] ? {bus.ld_req_addr[31:2], 2'b00} : 32'h0;
    check("rom_pc", {1'b0, bus.rom_pc}, {1'b0, exp_pc});

    if (eg[0]) q_if.push_back(exp_rsp(1'b1, bus.if_req_addr));
    if (eg[1]) q_ld.push_back(exp_rsp(1'b0, bus.ld_req_addr));

    if (eg[0]) m_starve = 0;
    else if (elig[0] && m_starve < STARVE_MAX) m_starve++;
    if (eg[0]) m_ptr = 1'b1;
    else if (eg[1]) m_ptr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (eg[p]) m_full[p] = 1'b1;
      else if (m_full[p] && rr[p]) m_full[p] = 1'b0;
    end
    last_if_rdy = bus.if_req_ready;
    last_ld_rdy = bus.ld_req_ready;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rst_n) sample();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [31:0] a);
    bus.if_req_valid = v;
    bus.if_req_addr  = a;
  endtask

  task automatic set_ld(input logic v, input logic [31:0] a);
    bus.ld_req_valid = v;
    bus.ld_req_addr  = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_if(1'b0, 32'h0);
    set_ld(1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_cleared();
    check1("rst_if_rsp_valid", bus.if_rsp_valid, 1'b0);
    check1("rst_ld_rsp_valid", bus.ld_rsp_valid, 1'b0);
    check("rst_if_rsp", {bus.if_rsp_err, bus.if_rsp_data}, 33'h0);
    check("rst_ld_rsp", {bus.ld_rsp_err, bus.ld_rsp_data}, 33'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_if(1'b0, 32'h0);
    set_ld(1'b0, 32'h0);
    bus.if_rsp_ready = 1'b0;
    bus.ld_rsp_ready = 1'b0;
    last_if_rdy = 1'b0;
    last_ld_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check_cleared();
    check1("rst_if_req_ready", bus.if_req_ready, 1'b0);
    check("rst_rom_pc", {1'b0, bus.rom_pc}, 33'h0);

    // Fetch-only streaming at one word per cycle
    bus.if_rsp_ready = 1'b1;
    bus.ld_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_if(1'b1, 32'(i * 4));
      cycle();
      check1("stream_grant", last_if_rdy, 1'b1);
    end
    set_if(1'b0, 32'h0);
    cycle();

    // Out of range and misaligned fetch; load ignores the low address bits
    set_if(1'b1, 32'h40);
    cycle();
    set_if(1'b1, 32'h06);
    cycle();
    set_if(1'b0, 32'h0);
    set_ld(1'b1, 32'h06);
    cycle();
    set_ld(1'b0, 32'h0);
    cycle();

    // Both ports busy: load priority with starvation guard, or round-robin
    for (int i = 0; i < 10; i++) begin
      set_if(1'b1, 32'(4 * (i % 4)));
      set_ld(1'b1, 32'(4 * ((i + 5) % 16)));
      cycle();
`ifdef ROM_ARB_RR_EN
      check1("tie_pattern", last_if_rdy, (i % 2) == 0);
`else
      check1("tie_pattern", last_if_rdy, (i % 4) == 3);
`endif
    end
    set_if(1'b0, 32'h0);
    set_ld(1'b0, 32'h0);
    cycle();

    // Fetch response held for five cycles while loads keep flowing
    bus.if_rsp_ready = 1'b0;
    set_if(1'b1, 32'h8);
    cycle();
    for (int k = 0; k < 5; k++) begin
      set_if(1'b1, 32'hC);
      set_ld(1'b1, 32'(4 * k));
      cycle();
      check1("hold_if_blocked", last_if_rdy, 1'b0);
      check1("hold_ld_granted", last_ld_rdy, 1'b1);
    end
    bus.if_rsp_ready = 1'b1;
    set_ld(1'b0, 32'h0);
    cycle();
    check1("drain_regrant", last_if_rdy, 1'b1);
    set_if(1'b0, 32'h0);
    cycle();

    // Reset with both slots full
    bus.if_rsp_ready = 1'b0;
    bus.ld_rsp_ready = 1'b0;
    set_if(1'b1, 32'h8);
    cycle();
    set_if(1'b0, 32'h0);
    set_ld(1'b1, 32'h100);
    cycle();
    set_ld(1'b0, 32'h0);
    cycle();
    do_reset();
    check_cleared();

    // Counter and pointer clear on reset: first tie afterwards
    bus.if_rsp_ready = 1'b1;
    bus.ld_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_if(1'b1, 32'h4);
      set_ld(1'b1, 32'h8);
      cycle();
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_if(1'b1, 32'(4 * i));
      set_ld(1'b1, 32'h4);
      cycle();
      if (i == 0) begin
`ifdef ROM_ARB_RR_EN
        check1("post_rst_tie", last_if_rdy, 1'b1);
`else
        check1("post_rst_tie", last_if_rdy, 1'b0);
`endif
      end
    end
    set_if(1'b0, 32'h0);
    set_ld(1'b0, 32'h0);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single combinational read port of the instruction ROM between the core's instruction-fetch port and its data-load port. Each port gets a valid/ready request channel and a registered, held response channel. Load requests win by default, and a starvation guard bounds fetch latency. The block sits between the core front-end/LSU and the ROM, which is driven through `rom_pc` and returns `rom_instruction` in the same cycle.

## Interface

- `DEPTH_LOG2`, default 4: ROM has 2**DEPTH_LOG2 words.
- `STARVE_MAX`, default 3: consecutive blocked fetch cycles before fetch is forced to win.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `if_req_valid` input 1: fetch request present.
- `if_req_ready` output 1: fetch request accepted this cycle.
- `if_req_addr` input 32: fetch byte address.
- `if_rsp_valid` output 1: fetch response held.
- `if_rsp_ready` input 1: fetch response consumed.
- `if_rsp_data` output 32: fetched word.
- `if_rsp_err` output 1: fetch out of range or misaligned.
- `ld_req_valid`, `ld_req_ready`, `ld_req_addr`, `ld_rsp_valid`, `ld_rsp_ready`, `ld_rsp_data`, `ld_rsp_err`: same widths and directions for the load port.
- `rom_pc` output 32: address presented to the ROM.
- `rom_instruction` input 32: ROM word, combinational from `rom_pc`.

## Operation

- Each port has one response slot, so at most one request is outstanding per port.
- A port is eligible when its `req_valid` is high and its slot is empty, or its slot is being drained this cycle (`rsp_valid & rsp_ready`).
- At most one grant per cycle. The granted port sees `req_ready`=1, and the other sees 0.
- Default arbitration: load wins when both ports are eligible.
  - `starve_cnt` (2..8 bits, saturating) increments each cycle fetch is eligible and loses.
  - It clears on any fetch grant.
  - When `starve_cnt` == STARVE_MAX, fetch wins over load.
- `rom_pc` is driven by the granted address with bits [1:0] forced to 0. It is 0 when nothing is granted.
- On grant, the slot loads:
  - `rsp_data` = `rom_instruction`, `rsp_err` = 0 for a valid request.
  - Out of range (addr[31:2] >= 2**DEPTH_LOG2): `rsp_data` = 0, `rsp_err` = 1.
  - Fetch with addr[1:0] != 0: `rsp_data` = 0, `rsp_err` = 1. Loads ignore addr[1:0]; the LSU does byte selection.
- Slot states: EMPTY → FULL on grant. FULL → EMPTY on `rsp_ready`, unless regranted in the same cycle, in which case it stays FULL with the new data.
- `rsp_data` and `rsp_err` are stable while `rsp_valid` is high and `rsp_ready` is low.

## Timing

- Reset (`rst_n`=0 at an edge) clears:
  - both `rsp_valid`, `rsp_data`, and `rsp_err` to 0;
  - `starve_cnt` to 0;
  - the round-robin pointer to fetch.
- Reset mid-operation drops any held responses.
- `req_ready` is combinational from both `req_valid`s, both slot states, the `rsp_ready`s and `starve_cnt`. `req_ready` never depends combinationally on `rom_instruction`.
- Latency: a request granted in cycle N has its response visible in cycle N+1.
- Throughput is one grant per cycle. A single port alone reaches 1 word/cycle with `rsp_ready` held high.
- Both ports busy with load priority: fetch waits at most STARVE_MAX cycles, then is granted.
- Simultaneous drain and regrant on the same port is legal and loses no cycle.

## Configuration

- `ROM_ARB_RR_EN` defined:
  - Arbitration is strict round-robin. The pointer toggles to the other port after every grant; on a tie, the port the pointer names wins.
  - `starve_cnt` and STARVE_MAX are removed, and the parameter is ignored.
- Undefined: load priority with the starvation guard, as described above.

## Test plan

- Fetch-only, `if_rsp_ready`=1, addresses 0,4,8,12 on consecutive cycles:
  - grants every cycle;
  - responses 0x40000113, 0x01000193, 0x00108093, 0x00110023 one cycle later, `err`=0.
- Fetch at 0x40 and fetch at 0x06 (DEPTH_LOG2=4):
  - 0x40 → `if_rsp_err`=1, data 0;
  - 0x06 → misaligned, `err`=1, data 0.
  - Load at 0x06 → data = word 1, `err`=0.
- Both ports valid every cycle, both `rsp_ready`=1, STARVE_MAX=3:
  - load granted cycles 0–2, fetch at cycle 3, then load resumes.
  - With `ROM_ARB_RR_EN`: fetch and load alternate, fetch first.
- Fetch response held with `if_rsp_ready`=0 for 5 cycles:
  - `if_req_ready`=0 throughout, and data is stable.
  - Load is still granted each cycle.
  - When `rsp_ready` rises with a new valid request, drain and regrant happen in the same cycle.
- Assert `rst_n`=0 while both slots are FULL:
  - next cycle both `rsp_valid`=0, data 0, and the counter clears.
  - The first post-reset tie goes to load (default build) or fetch (`ROM_ARB_RR_EN`).
